// File: rtl/fwd_hazard_unit_pkg.sv
// Shared types and defaults for the EX-stage forwarding / hazard unit.
// Latency: n/a (types and helper function only).
// Backpressure: n/a.
//
// The tracker entry holds rd at RIDX_MAX bits. Narrower register indices are
// zero-extended, so a single struct type serves every legal RIDX_W.
package fwd_hazard_unit_pkg;

  localparam int XLEN_DEF      = 32;
  localparam int RIDX_W_DEF    = 5;
  localparam int RIDX_MAX      = 8;
  localparam int FWD_DEPTH_MAX = 4;

  typedef struct packed {
    logic                valid;
    logic [RIDX_MAX-1:0] rd;
    logic                we;
    logic                load;
  } trk_entry_t;

  // An entry can supply a value for register rs when it is live, writes a
  // register, and targets rs. x0 is hardwired to zero and never matches.
  function automatic logic fwd_hit(input trk_entry_t e, input logic [RIDX_MAX-1:0] rs);
    return e.valid && e.we && (e.rd != '0) && (e.rd == rs);
  endfunction

endpackage

// File: rtl/fwd_hazard_unit_branch_comp.sv
// Branch comparator: equality plus signed/unsigned less-than on two operands.
// Latency: purely combinational.
// Backpressure: none.
//
// Ports:
//   a, b  : XLEN operands
//   brun  : 1 = unsigned compare, 0 = signed compare
//   breq  : a == b
//   brlt  : a < b under the selected signedness
module branch_comp #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            brun,
  output logic            breq,
  output logic            brlt
);

  assign breq = (a == b);
  assign brlt = brun ? (a < b) : ($signed(a) < $signed(b));

endmodule

// File: rtl/fwd_hazard_unit.sv
// EX-stage operand forwarding and load-use hazard detection.
// Latency: operand and compare paths are combinational; the EX register and tracker update in 1 cycle.
// Backpressure: stall holds ID and EX for one cycle per load-use pair, and a bubble enters MEM.
//
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   id_*                     : instruction presented by ID (valid, rs1, rs2, rd, we, load)
//   flush                    : kill the EX instruction (taken branch / jump)
//   reg_rs1, reg_rs2         : register-file read data for the EX instruction
//   fwd_data[k]              : result currently held by tracked entry k (0 = MEM, 1 = WB, ...)
//   pc, imm, a_sel, b_sel    : operand mux sources and selects
//   brun                     : unsigned branch compare
//   op_a, op_b, store_data   : ALU operands and forwarded store value
//   breq, brlt               : branch compare results on the forwarded operands
//   stall, ex_valid          : load-use stall, EX occupancy
module fwd_hazard_unit
  import fwd_hazard_unit_pkg::*;
#(
  parameter int XLEN      = XLEN_DEF,
  parameter int RIDX_W    = RIDX_W_DEF,  // must not exceed RIDX_MAX
  parameter int FWD_DEPTH = 2            // legal range 1..FWD_DEPTH_MAX
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           id_valid,
  input  logic [RIDX_W-1:0]              id_rs1,
  input  logic [RIDX_W-1:0]              id_rs2,
  input  logic [RIDX_W-1:0]              id_rd,
  input  logic                           id_we,
  input  logic                           id_load,
  input  logic                           flush,
  input  logic [XLEN-1:0]                reg_rs1,
  input  logic [XLEN-1:0]                reg_rs2,
  input  logic [FWD_DEPTH-1:0][XLEN-1:0] fwd_data,
  input  logic [XLEN-1:0]                pc,
  input  logic [XLEN-1:0]                imm,
  input  logic                           a_sel,
  input  logic                           b_sel,
  input  logic                           brun,
  output logic [XLEN-1:0]                op_a,
  output logic [XLEN-1:0]                op_b,
  output logic [XLEN-1:0]                store_data,
  output logic                           breq,
  output logic                           brlt,
  output logic                           stall,
  output logic                           ex_valid
);

  // EX register: destination info travels as a tracker entry so it can be
  // shifted straight into entry 0; the source indices stay alongside.
  trk_entry_t          ex_ent;
  logic [RIDX_MAX-1:0] ex_rs1;
  logic [RIDX_MAX-1:0] ex_rs2;

  trk_entry_t          trk [FWD_DEPTH];

  trk_entry_t          id_ent;
  logic [RIDX_MAX-1:0] id_rs1_w;
  logic [RIDX_MAX-1:0] id_rs2_w;

  logic [XLEN-1:0]     fwd_rs1;
  logic [XLEN-1:0]     fwd_rs2;

  // Zero-extend the ID indices to the tracker's fixed rd width.
  always_comb begin
    id_rs1_w               = '0;
    id_rs2_w               = '0;
    id_ent                 = '0;
    id_rs1_w[RIDX_W-1:0]   = id_rs1;
    id_rs2_w[RIDX_W-1:0]   = id_rs2;
    id_ent.valid           = id_valid;
    id_ent.rd[RIDX_W-1:0]  = id_rd;
    id_ent.we              = id_we;
    id_ent.load            = id_load;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_ent <= '0;
      ex_rs1 <= '0;
      ex_rs2 <= '0;
      for (int k = 0; k < FWD_DEPTH; k++) begin
        trk[k] <= '0;
      end
    end else begin
      // Flush beats stall: a stalled instruction that is being killed must
      // not linger in EX.
      if (flush) begin
        ex_ent.valid <= 1'b0;
      end else if (!stall) begin
        ex_ent <= id_ent;
        ex_rs1 <= id_rs1_w;
        ex_rs2 <= id_rs2_w;
      end

      // A stalled or flushed EX instruction does not advance; MEM gets a bubble.
      trk[0] <= (stall || flush) ? trk_entry_t'('0) : ex_ent;
      for (int k = 1; k < FWD_DEPTH; k++) begin
        trk[k] <= trk[k-1];
      end
    end
  end

  // Walk from the oldest entry to the youngest so the youngest match is
  // written last and wins. A load in entry 0 has no data yet, so it is
  // skipped and an older entry (or the register file) supplies the value.
  always_comb begin
    fwd_rs1 = reg_rs1;
    fwd_rs2 = reg_rs2;
    for (int k = FWD_DEPTH - 1; k >= 0; k--) begin
      if (!(k == 0 && trk[k].load)) begin
        if (fwd_hit(trk[k], ex_rs1)) fwd_rs1 = fwd_data[k];
        if (fwd_hit(trk[k], ex_rs2)) fwd_rs2 = fwd_data[k];
      end
    end
  end

  // Load-use: the load in entry 0 leaves MEM next cycle, after which entry 1
  // can forward its result. That bounds the stall to a single cycle.
  assign stall = ex_ent.valid && trk[0].load &&
                 (fwd_hit(trk[0], ex_rs1) || fwd_hit(trk[0], ex_rs2));

  assign ex_valid   = ex_ent.valid;
  assign op_a       = a_sel ? pc  : fwd_rs1;
  assign op_b       = b_sel ? imm : fwd_rs2;
  assign store_data = fwd_rs2;

  branch_comp #(
    .XLEN (XLEN)
  ) u_branch_comp (
    .a    (fwd_rs1),
    .b    (fwd_rs2),
    .brun (brun),
    .breq (breq),
    .brlt (brlt)
  );

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit with hand-computed expectations.
// Inputs change 1 time unit after the rising edge; outputs are checked 1 time unit later.
// Each entry in the pipeline comments is listed as EX / entry0 / entry1 after the edge.
module tb_fwd_hazard_unit;

  logic             clk = 1'b0;
  logic             rst;
  logic             id_valid;
  logic [4:0]       id_rs1, id_rs2, id_rd;
  logic             id_we, id_load;
  logic             flush;
  logic [31:0]      reg_rs1, reg_rs2;
  logic [1:0][31:0] fwd_data;
  logic [31:0]      pc, imm;
  logic             a_sel, b_sel, brun;
  logic [31:0]      op_a, op_b, store_data;
  logic             breq, brlt, stall, ex_valid;

  int total = 0;
  int bad   = 0;

  fwd_hazard_unit #(
    .XLEN      (32),
    .RIDX_W    (5),
    .FWD_DEPTH (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .id_valid   (id_valid),
    .id_rs1     (id_rs1),
    .id_rs2     (id_rs2),
    .id_rd      (id_rd),
    .id_we      (id_we),
    .id_load    (id_load),
    .flush      (flush),
    .reg_rs1    (reg_rs1),
    .reg_rs2    (reg_rs2),
    .fwd_data   (fwd_data),
    .pc         (pc),
    .imm        (imm),
    .a_sel      (a_sel),
    .b_sel      (b_sel),
    .brun       (brun),
    .op_a       (op_a),
    .op_b       (op_b),
    .store_data (store_data),
    .breq       (breq),
    .brlt       (brlt),
    .stall      (stall),
    .ex_valid   (ex_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input logic we, input logic ld);
    id_valid = 1'b1;
    id_rs1   = rs1;
    id_rs2   = rs2;
    id_rd    = rd;
    id_we    = we;
    id_load  = ld;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; flush = 1'b0;
    id_valid = 1'b0; id_rs1 = '0; id_rs2 = '0; id_rd = '0; id_we = 1'b0; id_load = 1'b0;
    reg_rs1 = 32'h99; reg_rs2 = 32'h77; fwd_data = '0;
    pc = 32'h1000; imm = 32'h40; a_sel = 1'b0; b_sel = 1'b0; brun = 1'b0;

    // Reset state
    tick(); tick();
    #1;
    chk("rst_ex_valid", {31'd0, ex_valid}, 32'd0);
    chk("rst_stall",    {31'd0, stall},    32'd0);
    chk("rst_op_a_reg", op_a, 32'h99);
    chk("rst_op_b_reg", op_b, 32'h77);
    a_sel = 1'b1; b_sel = 1'b1; #1;
    chk("op_a_pc",  op_a, 32'h1000);
    chk("op_b_imm", op_b, 32'h40);
    a_sel = 1'b0; b_sel = 1'b0;
    rst = 1'b0;

    // Basic forward from MEM: EX reads x1 written by entry 0
    issue(0, 0, 1, 1, 0); tick();                     // EX=wr x1
    issue(1, 2, 3, 1, 0); tick();                     // EX=add x3,x1,x2 / x1
    fwd_data[0] = 32'h11; fwd_data[1] = 32'h22; #1;
    chk("fwd_mem_ex_valid", {31'd0, ex_valid}, 32'd1);
    chk("fwd_mem_stall",    {31'd0, stall},    32'd0);
    chk("fwd_mem_op_a",     op_a, 32'h11);
    chk("fwd_mem_op_b_reg", op_b, 32'h77);

    // Youngest wins: entries 0 and 1 both write x5
    issue(0, 0, 5, 1, 0); tick();                     // EX=x5(A) / x3 / x1
    issue(0, 0, 5, 1, 0); tick();                     // EX=x5(B) / A / x3
    issue(0, 5, 6, 1, 0); tick();                     // EX=rd x5 / B / A
    fwd_data[0] = 32'hA; fwd_data[1] = 32'hB; #1;
    chk("young_op_b",  op_b, 32'hA);
    chk("young_store", store_data, 32'hA);
    chk("young_op_a_x0", op_a, 32'h99);

    // Only entry 1 matches
    issue(5, 0, 8, 1, 0); tick();                     // EX=rs1 x5 / x6 / x5(B)
    #1;
    chk("wb_op_a", op_a, 32'hB);

    // Writes to x0 are never forwarded
    issue(0, 0, 0, 1, 0); tick();                     // EX=wr x0 / x8 / x6
    issue(0, 0, 11, 1, 0); tick();                    // EX=rd x0 / x0 / x8
    fwd_data[0] = 32'h5; #1;
    chk("x0_op_a", op_a, 32'h99);

    // Load-use: one stall cycle, then forward from entry 1
    issue(0, 0, 7, 1, 1); tick();                     // EX=ld x7 / x11 / x0
    issue(7, 0, 9, 1, 0); tick();                     // EX=use x7 / ld x7 / x11
    fwd_data[0] = 32'hDEAD; fwd_data[1] = 32'h77; #1;
    chk("lu_stall",      {31'd0, stall}, 32'd1);
    chk("lu_op_a_noload", op_a, 32'h99);
    issue(0, 0, 10, 1, 0); tick();                    // EX=use x7 (held) / bubble / ld x7
    #1;
    chk("lu_stall_drop", {31'd0, stall}, 32'd0);
    chk("lu_ex_held",    {31'd0, ex_valid}, 32'd1);
    chk("lu_op_a_wb",    op_a, 32'h77);
    tick();                                           // EX=x10 / x9 / bubble
    #1;
    chk("lu_next_stall", {31'd0, stall}, 32'd0);

    // Branch compares on non-forwarded operands
    reg_rs1 = 32'hFFFF_FFFF; reg_rs2 = 32'h1; brun = 1'b0; #1;
    chk("br_signed_lt", {31'd0, brlt}, 32'd1);
    chk("br_ne",        {31'd0, breq}, 32'd0);
    brun = 1'b1; #1;
    chk("br_unsigned_lt", {31'd0, brlt}, 32'd0);
    reg_rs1 = 32'h1; reg_rs2 = 32'hFFFF_FFFF; #1;
    chk("br_unsigned_lt2", {31'd0, brlt}, 32'd1);
    brun = 1'b0; #1;
    chk("br_signed_lt2", {31'd0, brlt}, 32'd0);
    reg_rs1 = 32'hFFFF_FFFF; #1;
    chk("br_eq",    {31'd0, breq}, 32'd1);
    chk("br_eq_lt", {31'd0, brlt}, 32'd0);
    reg_rs1 = 32'h99; reg_rs2 = 32'h77;

    // Flush during a load-use stall (rs2 side)
    issue(0, 0, 12, 1, 1); tick();                    // EX=ld x12 / x10 / x9
    issue(0, 12, 13, 1, 0); tick();                   // EX=use x12 / ld x12 / x10
    #1;
    chk("fl_stall_rs2", {31'd0, stall}, 32'd1);
    issue(1, 1, 14, 1, 0); flush = 1'b1; tick();
    flush = 1'b0; #1;
    chk("fl_ex_valid", {31'd0, ex_valid}, 32'd0);
    chk("fl_stall",    {31'd0, stall},    32'd0);

    // Reset in the middle of a stall
    issue(0, 0, 14, 1, 1); tick();                    // EX=ld x14
    issue(14, 0, 15, 1, 0); tick();                   // EX=use x14 / ld x14
    #1;
    chk("rs_stall", {31'd0, stall}, 32'd1);
    rst = 1'b1;
    issue(14, 3, 16, 1, 0); tick();
    #1;
    chk("rs_ex_valid", {31'd0, ex_valid}, 32'd0);
    chk("rs_stall_clr", {31'd0, stall},   32'd0);
    rst = 1'b0; tick();                               // EX=x16 reading x14, tracker empty
    fwd_data[0] = 32'h5A; fwd_data[1] = 32'h5B; #1;
    chk("post_rs_ex_valid", {31'd0, ex_valid}, 32'd1);
    chk("post_rs_stall",    {31'd0, stall},    32'd0);
    chk("post_rs_op_a",     op_a, 32'h99);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fwd_hazard_unit.md
FWD_HAZARD_UNIT -- requirements
Module: fwd_hazard_unit

Interface
REQ-001 Parameter XLEN, default 32, datapath width.
REQ-002 Parameter RIDX_W, default 5, register-index width; x0 is never forwarded.
REQ-003 Parameter FWD_DEPTH, default 2, number of tracked older stages (entry 0 = MEM, 1 = WB, ...); legal range 1..4.
REQ-004 One clock, synchronous active-high reset:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous active-high reset
id_valid  in  1  instruction in ID ready to enter EX
id_rs1, id_rs2  in  RIDX_W  source indices of ID instruction
id_rd  in  RIDX_W  destination index of ID instruction
id_we, id_load  in  1  ID instruction writes rd / is a load
flush  in  1  kill EX-stage instruction (taken branch / jump)
reg_rs1, reg_rs2  in  XLEN  register-file read data for EX instruction
fwd_data  in  FWD_DEPTH x XLEN  result of tracked entry k
pc, imm  in  XLEN  EX-stage PC and immediate
a_sel, b_sel  in  1  1 = operand A from pc / operand B from imm
brun  in  1  unsigned branch compare
op_a, op_b  out  XLEN  ALU operands
store_data  out  XLEN  forwarded rs2 value
breq, brlt  out  1  branch compare results on forwarded rs1/rs2
stall  out  1  hold PC and ID; bubble enters MEM
ex_valid  out  1  EX stage holds a live instruction

Function
REQ-005 EX register {valid, rs1, rs2, rd, we, load} loads ID fields when stall=0; holds when stall=1; valid cleared when flush=1 (flush overrides stall).
REQ-006 Tracker: each cycle entry k+1 <= entry k; entry 0 <= EX register, or an invalid bubble when stall=1 or flush=1.
REQ-007 Forwarded rs1 = fwd_data[k] for the lowest k whose entry is valid, we=1, rd==EX.rs1 and rd!=0; otherwise reg_rs1; rs2 identical.
REQ-008 Entry 0 with load=1 is never a forwarding source (data not yet available); lookup continues at k=1.
REQ-009 stall=1 combinationally when ex_valid=1, entry 0 valid, load=1, we=1, rd!=0 and rd equals EX.rs1 or EX.rs2; lasts exactly one cycle per load-use pair.
REQ-010 op_a = pc if a_sel else forwarded rs1; op_b = imm if b_sel else forwarded rs2; store_data = forwarded rs2.
REQ-011 breq = (fwd rs1 == fwd rs2); brlt = signed or, when brun=1, unsigned rs1 < rs2; both valid only while stall=0.
REQ-012 Operand/compare paths purely combinational (zero latency); tracker and EX register one-cycle latency.
REQ-013 Simultaneous flush and stall: EX invalidated, bubble into entry 0, stall deasserts next cycle.
REQ-014 Multiple matching entries: youngest wins; matches on rd=0 ignored.

Reset
REQ-015 On rst=1 at a clock edge: EX valid=0, all tracker entries invalid; stall=0, ex_valid=0; outputs default to reg/pc/imm paths.
REQ-016 Reset mid-stall discards the stalled instruction; first post-reset ID instruction enters EX on the next edge.

Structure
REQ-017 Shared package holds the tracker entry struct {valid, rd, we, load} and default XLEN/RIDX_W constants.
REQ-018 Compare logic instantiates the existing branch_comp sub-module with XLEN-wide inputs; no other sub-modules.

Verification
REQ-019 EX add x3 reads x1, entry 0 = {we, rd=1}, fwd_data[0]=0x11, reg_rs1=0x99 -> op_a=0x11, stall=0.
REQ-020 Entries 0 and 1 both write x5 (0xA / 0xB), EX reads x5 as rs2 -> op_b=0xA, store_data=0xA.
REQ-021 Entry 0 = load rd=7, EX reads x7 -> stall=1 for exactly one cycle; next cycle op_a = fwd_data[1].
REQ-022 Entry 0 writes x0 with fwd_data[0]=0x5, EX reads x0 -> op_a=reg_rs1.
REQ-023 fwd rs1=0xFFFFFFFF, rs2=0x1: brun=0 -> brlt=1; brun=1 -> brlt=0; equal values -> breq=1.
REQ-024 flush=1 during load-use stall -> ex_valid=0 next cycle, stall=0; rst mid-stall -> all state cleared.
